// File: rtl/mips_pkg.sv
// Shared definitions for the 5-bit-opcode MIPS controllers: opcodes,
// ALU operation codes, instruction classes and sequencer state codes.
package mips_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00011;
  localparam logic [4:0] OP_AND  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b00101;
  localparam logic [4:0] OP_XOR  = 5'b00110;
  localparam logic [4:0] OP_SR   = 5'b01000;
  localparam logic [4:0] OP_SRA  = 5'b01001;
  localparam logic [4:0] OP_SL   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b10010;
  localparam logic [4:0] OP_ANDI = 5'b10100;
  localparam logic [4:0] OP_ORI  = 5'b10101;
  localparam logic [4:0] OP_XORI = 5'b10110;
  localparam logic [4:0] OP_LW   = 5'b11100;
  localparam logic [4:0] OP_SW   = 5'b11101;
  localparam logic [4:0] OP_BEQ  = 5'b11110;
  localparam logic [4:0] OP_BNE  = 5'b11111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0111;
  localparam logic [3:0] ALU_SR  = 4'b1000;
  localparam logic [3:0] ALU_SL  = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_LD  = 3'd2,
    CLS_ST  = 3'd3,
    CLS_BR  = 3'd4,
    CLS_ILL = 3'd5
  } op_class_t;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_ADDR   = 3'd4,
    ST_MEM    = 3'd5,
    ST_LWB    = 3'd6,
    ST_BRANCH = 3'd7
  } state_t;

endpackage

// File: rtl/multicycle_controller_op_decode.sv
// Combinational opcode decoder: class, ALU operation, immediate select
// and legality. Used by both the single- and multi-cycle controllers.
module op_decode
  import mips_pkg::*;
(
  input  logic [4:0] i_op,
  output op_class_t  o_cls,
  output logic [3:0] o_alu_op,
  output logic       o_alu_src,
  output logic       o_legal
);

  // Opcode to control map; unknown opcodes fall through as illegal.
  always_comb begin
    o_cls     = CLS_ILL;
    o_alu_op  = ALU_ADD;
    o_alu_src = 1'b0;
    o_legal   = 1'b1;
    case (i_op)
      OP_ADD:  begin o_cls = CLS_R;  o_alu_op = ALU_ADD; end
      OP_SUB:  begin o_cls = CLS_R;  o_alu_op = ALU_SUB; end
      OP_AND:  begin o_cls = CLS_R;  o_alu_op = ALU_AND; end
      OP_OR:   begin o_cls = CLS_R;  o_alu_op = ALU_OR;  end
      OP_XOR:  begin o_cls = CLS_R;  o_alu_op = ALU_XOR; end
      OP_SR:   begin o_cls = CLS_R;  o_alu_op = ALU_SR;  end
      OP_SRA:  begin o_cls = CLS_R;  o_alu_op = ALU_SRA; end
      OP_SL:   begin o_cls = CLS_R;  o_alu_op = ALU_SL;  end
      OP_ADDI: begin o_cls = CLS_I;  o_alu_op = ALU_ADD; o_alu_src = 1'b1; end
      OP_ANDI: begin o_cls = CLS_I;  o_alu_op = ALU_AND; o_alu_src = 1'b1; end
      OP_ORI:  begin o_cls = CLS_I;  o_alu_op = ALU_OR;  o_alu_src = 1'b1; end
      OP_XORI: begin o_cls = CLS_I;  o_alu_op = ALU_XOR; o_alu_src = 1'b1; end
      OP_LW:   begin o_cls = CLS_LD; o_alu_op = ALU_ADD; o_alu_src = 1'b1; end
      OP_SW:   begin o_cls = CLS_ST; o_alu_op = ALU_ADD; o_alu_src = 1'b1; end
      OP_BEQ:  begin o_cls = CLS_BR; o_alu_op = ALU_SUB; end
      OP_BNE:  begin o_cls = CLS_BR; o_alu_op = ALU_SUB; end
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for the 5-bit-opcode MIPS datapath.
// Memory handshake: a request strobe (ImemRd in FETCH, DmemRd/DmemWr in
// MEM) is held high until the cycle in which mem_ready = 1; that cycle
// completes the access and the FSM moves on at the next edge. mem_ready
// is ignored whenever no request strobe is high.
module multicycle_controller
  import mips_pkg::*;
#(
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [4:0]          inst_op,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                PCWr,
  output logic                IRWr,
  output logic                PCSrc,
  output logic                RegSrc,
  output logic                RegEn,
  output logic                ALUSrc,
  output logic [3:0]          ALUOp,
  output logic                ImemRd,
  output logic                DmemRd,
  output logic                DmemWr,
  output logic                WrSrc,
  output logic                trap,
  output logic [2:0]          state_o,
  output logic [RETIRE_W-1:0] retired
);

  state_t              r_state;
  state_t              w_next;
  logic [4:0]          r_op;
  logic                r_trap;
  logic [RETIRE_W-1:0] r_retired;

  logic       w_retire, w_set_trap;
  logic       w_pcwr, w_irwr, w_pcsrc, w_regsrc, w_regen, w_alusrc;
  logic       w_imemrd, w_dmemrd, w_dmemwr, w_wrsrc;
  logic [3:0] w_aluop;

  logic [4:0] w_dec_op;
  op_class_t  w_cls;
  logic [3:0] w_dec_alu_op;
  logic       w_dec_alu_src;
  logic       w_legal;

  // In DECODE the opcode is not yet registered, so decode it straight from
  // the instruction register; later states use the captured copy.
  assign w_dec_op = (r_state == ST_DECODE) ? inst_op : r_op;

  op_decode u_op_decode (
    .i_op      (w_dec_op),
    .o_cls     (w_cls),
    .o_alu_op  (w_dec_alu_op),
    .o_alu_src (w_dec_alu_src),
    .o_legal   (w_legal)
  );

  // State, captured opcode, sticky trap and retired counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_FETCH;
      r_op      <= 5'd0;
      r_trap    <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE && !r_trap) r_op <= inst_op;
      if (w_set_trap) r_trap <= 1'b1;
      if (w_retire) r_retired <= r_retired + 1'b1;
    end
  end

  // Next state and control outputs; a set trap freezes the FSM.
  always_comb begin
    w_next     = r_state;
    w_retire   = 1'b0;
    w_set_trap = 1'b0;
    w_pcwr     = 1'b0;
    w_irwr     = 1'b0;
    w_pcsrc    = 1'b0;
    w_regsrc   = 1'b0;
    w_regen    = 1'b0;
    w_alusrc   = 1'b0;
    w_aluop    = ALU_ADD;
    w_imemrd   = 1'b0;
    w_dmemrd   = 1'b0;
    w_dmemwr   = 1'b0;
    w_wrsrc    = 1'b0;
    if (!r_trap) begin
      case (r_state)
        ST_FETCH: begin
          if (run) begin
            w_imemrd = 1'b1;
            if (mem_ready) begin
              w_irwr = 1'b1;
              w_pcwr = 1'b1;
              w_next = ST_DECODE;
            end
          end
        end
        ST_DECODE: begin
          if (!w_legal) begin
            w_set_trap = 1'b1;
          end else begin
            case (w_cls)
              CLS_R, CLS_I:   w_next = ST_EXEC;
              CLS_LD, CLS_ST: w_next = ST_ADDR;
              default:        w_next = ST_BRANCH;
            endcase
          end
        end
        ST_EXEC: begin
          w_alusrc = w_dec_alu_src;
          w_aluop  = w_dec_alu_op;
          w_next   = ST_WB;
        end
        ST_WB: begin
          w_alusrc = w_dec_alu_src;
          w_aluop  = w_dec_alu_op;
          w_regen  = 1'b1;
          w_wrsrc  = 1'b1;
          w_regsrc = (w_cls == CLS_R);
          w_retire = 1'b1;
          w_next   = ST_FETCH;
        end
        ST_ADDR: begin
          w_alusrc = 1'b1;
          w_aluop  = ALU_ADD;
          w_next   = ST_MEM;
        end
        ST_MEM: begin
          w_alusrc = 1'b1;
          w_aluop  = ALU_ADD;
          w_dmemrd = (w_cls == CLS_LD);
          w_dmemwr = (w_cls == CLS_ST);
          if (mem_ready) begin
            if (w_cls == CLS_LD) begin
              w_next = ST_LWB;
            end else begin
              w_retire = 1'b1;
              w_next   = ST_FETCH;
            end
          end
        end
        ST_LWB: begin
          w_regen  = 1'b1;
          w_retire = 1'b1;
          w_next   = ST_FETCH;
        end
        ST_BRANCH: begin
          w_aluop  = ALU_SUB;
          w_pcsrc  = (r_op == OP_BNE) ? !zero : zero;
          w_pcwr   = w_pcsrc;
          w_retire = 1'b1;
          w_next   = ST_FETCH;
        end
        default: w_next = ST_FETCH;
      endcase
    end
  end

  // Enables and strobes are forced low for as long as reset is asserted.
  assign PCWr    = rst_n & w_pcwr;
  assign IRWr    = rst_n & w_irwr;
  assign PCSrc   = rst_n & w_pcsrc;
  assign RegEn   = rst_n & w_regen;
  assign ImemRd  = rst_n & w_imemrd;
  assign DmemRd  = rst_n & w_dmemrd;
  assign DmemWr  = rst_n & w_dmemwr;
  assign RegSrc  = w_regsrc;
  assign ALUSrc  = w_alusrc;
  assign ALUOp   = w_aluop;
  assign WrSrc   = w_wrsrc;
  assign trap    = r_trap;
  assign state_o = r_state;
  assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed per-cycle vectors with
// hand-written expected outputs, checked by a negedge scoreboard monitor.
module tb_multicycle_controller;

  localparam int RW = 8;
  localparam int W  = 18 + RW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b1;
  logic [4:0]    inst_op = 5'd0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b1;
  logic          PCWr, IRWr, PCSrc, RegSrc, RegEn, ALUSrc;
  logic [3:0]    ALUOp;
  logic          ImemRd, DmemRd, DmemWr, WrSrc, trap;
  logic [2:0]    state_o;
  logic [RW-1:0] retired;

  logic [W-1:0]  exp_q[$];
  string         nm_q[$];
  logic [RW-1:0] ret = '0;
  int            n_tests = 0;
  int            n_fail = 0;

  // clock / reset
  always #5 clk = ~clk;

  multicycle_controller #(.RETIRE_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .inst_op(inst_op), .zero(zero),
    .mem_ready(mem_ready), .PCWr(PCWr), .IRWr(IRWr), .PCSrc(PCSrc),
    .RegSrc(RegSrc), .RegEn(RegEn), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
    .ImemRd(ImemRd), .DmemRd(DmemRd), .DmemWr(DmemWr), .WrSrc(WrSrc),
    .trap(trap), .state_o(state_o), .retired(retired)
  );

  // fl = {trap,PCWr,IRWr,PCSrc,RegSrc,RegEn,ALUSrc}, mf = {ImemRd,DmemRd,DmemWr,WrSrc}
  function automatic logic [W-1:0] mk(input logic [2:0] st, input logic [6:0] fl,
                                       input logic [3:0] aluop, input logic [3:0] mf);
    return {st, fl, aluop, mf, ret};
  endfunction

  // driver: apply one cycle of inputs and queue the expected outputs
  task automatic cyc(input logic rn, input logic r, input logic [4:0] op,
                     input logic z, input logic rdy, input logic [W-1:0] e,
                     input string nm, input bit inc);
    @(posedge clk); #1;
    rst_n = rn; run = r; inst_op = op; zero = z; mem_ready = rdy;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    if (inc) ret = ret + 1'b1;
  endtask

  task automatic fetch_decode(input logic [4:0] op);
    cyc(1, 1, 5'd0, 0, 1, mk(3'd0, 7'b0110000, 4'h0, 4'b1000), "fetch", 0);
    cyc(1, 1, op, 0, 1, mk(3'd1, 7'b0000000, 4'h0, 4'b0000), "decode", 0);
  endtask

  task automatic do_alu(input logic [4:0] op, input logic is_i,
                        input logic [3:0] aluop, input logic rm);
    fetch_decode(op);
    cyc(1, rm, op, 0, 1, mk(3'd2, {6'b0, is_i}, aluop, 4'b0000), "exec", 0);
    cyc(1, rm, op, 0, 1, mk(3'd3, {4'b0, ~is_i, 1'b1, is_i}, aluop, 4'b0001), "wb", 1);
  endtask

  task automatic do_mem(input logic is_lw, input int waits);
    logic [4:0] op;
    op = is_lw ? 5'b11100 : 5'b11101;
    fetch_decode(op);
    cyc(1, 1, op, 0, 1, mk(3'd4, 7'b0000001, 4'h0, 4'b0000), "addr", 0);
    for (int i = 0; i < waits; i++)
      cyc(1, 1, op, 0, 0, mk(3'd5, 7'b0000001, 4'h0, {1'b0, is_lw, ~is_lw, 1'b0}), "mem_wait", 0);
    cyc(1, 1, op, 0, 1, mk(3'd5, 7'b0000001, 4'h0, {1'b0, is_lw, ~is_lw, 1'b0}), "mem_done", !is_lw);
    if (is_lw)
      cyc(1, 1, op, 0, 1, mk(3'd6, 7'b0000010, 4'h0, 4'b0000), "lwb", 1);
  endtask

  task automatic do_br(input logic is_bne, input logic z);
    logic t;
    t = is_bne ? ~z : z;
    fetch_decode(is_bne ? 5'b11111 : 5'b11110);
    cyc(1, 1, 5'd0, z, 1, mk(3'd7, {1'b0, t, 1'b0, t, 3'b000}, 4'b0001, 4'b0000), "branch", 1);
  endtask

  // scoreboard monitor: compare every queued expectation mid-cycle
  always @(negedge clk) begin
    logic [W-1:0] e, act;
    string nm;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      nm  = nm_q.pop_front();
      act = {state_o, trap, PCWr, IRWr, PCSrc, RegSrc, RegEn, ALUSrc, ALUOp,
             ImemRd, DmemRd, DmemWr, WrSrc, retired};
      n_tests++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", nm, act, e);
      end
    end
  end

  initial begin
    // reset with run and mem_ready high: nothing may strobe
    cyc(0, 1, 5'd0, 0, 1, mk(3'd0, 7'b0, 4'h0, 4'b0000), "reset0", 0);
    cyc(0, 1, 5'd0, 0, 1, mk(3'd0, 7'b0, 4'h0, 4'b0000), "reset1", 0);
    cyc(1, 0, 5'd0, 0, 1, mk(3'd0, 7'b0, 4'h0, 4'b0000), "idle", 0);

    do_alu(5'b00010, 1'b0, 4'b0000, 1'b1);   // add
    do_alu(5'b10101, 1'b1, 4'b0101, 1'b1);   // ori
    do_alu(5'b01001, 1'b0, 4'b1010, 1'b1);   // sra
    do_alu(5'b10100, 1'b1, 4'b0100, 1'b1);   // andi
    do_mem(1'b1, 2);                         // lw, two wait states
    do_mem(1'b0, 0);                         // sw, no wait
    cyc(1, 1, 5'd0, 0, 0, mk(3'd0, 7'b0, 4'h0, 4'b1000), "fetch_wait", 0);
    do_br(1'b0, 1'b1);                       // beq taken
    do_br(1'b1, 1'b1);                       // bne not taken
    do_br(1'b1, 1'b0);                       // bne taken
    do_br(1'b0, 1'b0);                       // beq not taken

    // run dropped after fetch: instruction completes, then idle
    do_alu(5'b01010, 1'b0, 4'b1001, 1'b0);   // sl
    cyc(1, 0, 5'd0, 0, 1, mk(3'd0, 7'b0, 4'h0, 4'b0000), "idle_after", 0);

    // reset during a sw MEM wait
    fetch_decode(5'b11101);
    cyc(1, 1, 5'b11101, 0, 1, mk(3'd4, 7'b0000001, 4'h0, 4'b0000), "sw_addr", 0);
    cyc(1, 1, 5'b11101, 0, 0, mk(3'd5, 7'b0000001, 4'h0, 4'b0010), "sw_wait", 0);
    cyc(0, 1, 5'b11101, 0, 0, mk(3'd5, 7'b0000001, 4'h0, 4'b0000), "sw_rst", 0);
    ret = '0;
    cyc(1, 0, 5'd0, 0, 1, mk(3'd0, 7'b0, 4'h0, 4'b0000), "post_rst", 0);

    // retired counter wraps from all-ones to zero
    for (int i = 0; i < (1 << RW); i++) do_br(1'b0, 1'b1);
    cyc(1, 0, 5'd0, 0, 1, mk(3'd0, 7'b0, 4'h0, 4'b0000), "wrap_idle", 0);

    // illegal opcode: sticky trap, no strobes despite run
    fetch_decode(5'b00000);
    for (int i = 0; i < 20; i++)
      cyc(1, 1, 5'd0, 0, 1, mk(3'd1, 7'b1000000, 4'h0, 4'b0000), "trap_hold", 0);
    cyc(0, 1, 5'd0, 0, 1, mk(3'd1, 7'b1000000, 4'h0, 4'b0000), "trap_rst", 0);
    ret = '0;
    cyc(1, 0, 5'd0, 0, 1, mk(3'd0, 7'b0, 4'h0, 4'b0000), "trap_clr", 0);

    @(posedge clk);
    @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
